// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmitter device: shifter state encoding,
// control/status register bit map and serial frame constants.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_e;

  localparam int CTRL_READY = 0;
  localparam int CTRL_OVR   = 2;
  localparam int CTRL_IE    = 4;
  localparam int CTRL_IDLE  = 5;
  localparam int CTRL_PAR   = 8;

  localparam int   DATA_BITS  = 8;
  localparam int   IDX_BITS   = $clog2(DATA_BITS);
  localparam logic STOP_LEVEL = 1'b1;
  localparam logic IDLE_LEVEL = 1'b1;

  function automatic logic even_parity(input logic [DATA_BITS-1:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Byte FIFO between the device bus and the serial shifter. Pushes while full
// and pops while empty are ignored; the caller owns overrun reporting.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int FDEPTH = 4,
  parameter int FBITS  = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 push,
  input  logic                 pop,
  input  logic [DATA_BITS-1:0] wr_data,
  output logic [DATA_BITS-1:0] rd_data,
  output logic                 full,
  output logic                 empty,
  output logic [FBITS:0]       count
);

  logic [DATA_BITS-1:0] mem_q [FDEPTH];
  logic [FBITS-1:0]     wr_ptr_q, wr_ptr_d;
  logic [FBITS-1:0]     rd_ptr_q, rd_ptr_d;
  logic [FBITS:0]       count_q, count_d;
  logic                 do_push, do_pop;

  assign full    = (count_q == (FBITS+1)'(FDEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rd_data = mem_q[rd_ptr_q];
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  // NOTE: every variable gets a default at the top of always_comb so no path leaves it unassigned (no latch).
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + FBITS'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + FBITS'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (FBITS+1)'(1);
      2'b01:   count_d = count_q - (FBITS+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage has no reset; the pointers and count alone decide which entries are valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/uart_tx_dev.sv
// Memory-mapped 8N1 UART transmitter on the shared device bus, with a byte FIFO,
// control/status register and interrupt. Define UART_TX_PARITY_EN for 8E1 framing.
module uart_tx_dev
  import uart_pkg::*;
#(
  parameter int               ABITS   = 16,
  parameter int               DBITS   = 16,
  parameter logic [ABITS-1:0] DADDR   = 16'hFFD0,
  parameter logic [ABITS-1:0] CADDR   = 16'hFFD4,
  parameter int               FDEPTH  = 4,
  parameter int               FBITS   = 2,
  parameter int               BAUDDIV = 434,
  parameter int               BAUDB   = 9
) (
  input  logic             CLK,
  input  logic             INIT,
  input  logic             LOCK,
  input  logic [ABITS-1:0] ABUS,
  inout  wire  [DBITS-1:0] RBUS,
  input  logic             RE,
  input  logic [DBITS-1:0] WBUS,
  input  logic             WE,
  output logic             INTR,
  output logic             TXD
);

  localparam logic [BAUDB-1:0]    BAUD_LAST = BAUDB'(BAUDDIV - 1);
  localparam logic [IDX_BITS-1:0] LAST_BIT  = IDX_BITS'(DATA_BITS - 1);

  logic data_sel, ctrl_sel, data_wr, ctrl_wr;
  logic [DATA_BITS-1:0] fifo_head;
  logic                 fifo_full, fifo_empty, fifo_pop;
  logic [FBITS:0]       fifo_count;

  tx_state_e            state_q, state_d;
  logic [BAUDB-1:0]     baud_q, baud_d;
  logic [IDX_BITS-1:0]  bit_idx_q, bit_idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 txd_q, txd_d;
  logic                 ie_q, ie_d;
  logic                 ovr_q, ovr_d;
  logic                 baud_tick, dev_idle;
  logic [DBITS-1:0]     ctrl_word, rd_word;
  logic                 wbus_unused;
`ifdef UART_TX_PARITY_EN
  logic                 parity_q, parity_d;
`endif

  assign data_sel    = (ABUS == DADDR);
  assign ctrl_sel    = (ABUS == CADDR);
  assign data_wr     = WE & LOCK & data_sel;
  assign ctrl_wr     = WE & LOCK & ctrl_sel;
  assign wbus_unused = ^WBUS[DBITS-1:DATA_BITS];

  uart_tx_fifo #(
    .FDEPTH (FDEPTH),
    .FBITS  (FBITS)
  ) u_fifo (
    .clk     (CLK),
    .rst     (INIT),
    .push    (data_wr & ~fifo_full),
    .pop     (fifo_pop),
    .wr_data (WBUS[DATA_BITS-1:0]),
    .rd_data (fifo_head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  // Overrun is sticky: only a control write with bit 2 low clears it.
  always_comb begin
    ie_d  = ie_q;
    ovr_d = ovr_q;
    if (ctrl_wr) begin
      ie_d  = WBUS[CTRL_IE];
      ovr_d = ovr_q & WBUS[CTRL_OVR];
    end
    if (data_wr && fifo_full) ovr_d = 1'b1;
  end

  always_ff @(posedge CLK or posedge INIT) begin
    if (INIT) begin
      ie_q  <= 1'b0;
      ovr_q <= 1'b0;
    end else begin
      ie_q  <= ie_d;
      ovr_q <= ovr_d;
    end
  end

  assign dev_idle = fifo_empty & (state_q == ST_IDLE);
  assign INTR     = ie_q & ~fifo_full;

  always_comb begin
    ctrl_word             = '0;
    ctrl_word[CTRL_READY] = ~fifo_full;
    ctrl_word[CTRL_OVR]   = ovr_q;
    ctrl_word[CTRL_IE]    = ie_q;
    ctrl_word[CTRL_IDLE]  = dev_idle;
`ifdef UART_TX_PARITY_EN
    ctrl_word[CTRL_PAR]   = 1'b1;
`endif
  end

  assign rd_word = ctrl_sel ? ctrl_word : DBITS'(fifo_count);
  assign RBUS    = (RE && (data_sel || ctrl_sel)) ? rd_word : {DBITS{1'bz}};

  // Shifter state register.
  always_ff @(posedge CLK or posedge INIT) begin
    if (INIT) begin
      state_q   <= ST_IDLE;
      baud_q    <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
    end else begin
      state_q   <= state_d;
      baud_q    <= baud_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
    end
  end

`ifdef UART_TX_PARITY_EN
  always_ff @(posedge CLK or posedge INIT) begin
    if (INIT) parity_q <= 1'b0;
    else      parity_q <= parity_d;
  end
`endif

  assign baud_tick = (baud_q == BAUD_LAST);

  // Next-state logic: the baud counter restarts on every bit boundary.
  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q + BAUDB'(1);
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    fifo_pop  = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_d  = parity_q;
`endif
    case (state_q)
      ST_IDLE: begin
        baud_d = '0;
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          shift_d  = fifo_head;
          state_d  = ST_START;
`ifdef UART_TX_PARITY_EN
          parity_d = even_parity(fifo_head);
`endif
        end
      end
      ST_START: begin
        if (baud_tick) begin
          baud_d    = '0;
          bit_idx_d = '0;
          state_d   = ST_DATA;
        end
      end
      ST_DATA: begin
        if (baud_tick) begin
          baud_d  = '0;
          shift_d = shift_q >> 1;
          if (bit_idx_q == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
          end else begin
            bit_idx_d = bit_idx_q + IDX_BITS'(1);
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        if (baud_tick) begin
          baud_d  = '0;
          state_d = ST_STOP;
        end
      end
`endif
      ST_STOP: begin
        if (baud_tick) begin
          baud_d  = '0;
          state_d = ST_IDLE;
        end
      end
      default: begin
        baud_d  = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // Line level follows the current state; registering it keeps TXD glitch-free.
  always_comb begin
    txd_d = IDLE_LEVEL;
    case (state_q)
      ST_START:  txd_d = 1'b0;
      ST_DATA:   txd_d = shift_q[0];
`ifdef UART_TX_PARITY_EN
      ST_PARITY: txd_d = parity_q;
`endif
      ST_STOP:   txd_d = STOP_LEVEL;
      default:   txd_d = IDLE_LEVEL;
    endcase
  end

  always_ff @(posedge CLK or posedge INIT) begin
    if (INIT) txd_q <= IDLE_LEVEL;
    else      txd_q <= txd_d;
  end

  assign TXD = txd_q;

endmodule

// File: tb/tb_uart_tx_dev.sv
// Directed self-checking bench for uart_tx_dev with BAUDDIV=4; expectations
// switch to 8E1 framing when UART_TX_PARITY_EN is defined.
module tb_uart_tx_dev;

  localparam int BAUD = 4;
  localparam logic [15:0] DADDR = 16'hFFD0;
  localparam logic [15:0] CADDR = 16'hFFD4;
`ifdef UART_TX_PARITY_EN
  localparam int          NBITS = 11;
  localparam logic [15:0] PAR   = 16'h0100;
`else
  localparam int          NBITS = 10;
  localparam logic [15:0] PAR   = 16'h0000;
`endif
  localparam int FRAME = BAUD * NBITS;

  logic        clk = 1'b0;
  logic        init, lock, re, we;
  logic [15:0] abus, wbus;
  wire  [15:0] rbus;
  logic        intr, txd;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  uart_tx_dev #(
    .BAUDDIV (BAUD),
    .BAUDB   (2)
  ) dut (
    .CLK  (clk),
    .INIT (init),
    .LOCK (lock),
    .ABUS (abus),
    .RBUS (rbus),
    .RE   (re),
    .WBUS (wbus),
    .WE   (we),
    .INTR (intr),
    .TXD  (txd)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [15:0] a, input logic [15:0] d);
    abus = a;
    wbus = d;
    we   = 1'b1;
    @(posedge clk);
    #1;
    we   = 1'b0;
  endtask

  task automatic bus_read(input logic [15:0] a, output logic [15:0] d);
    abus = a;
    re   = 1'b1;
    #1;
    d    = rbus;
    re   = 1'b0;
    #1;
  endtask

  // Writes one byte into an idle, empty device and checks every TXD cycle of its frame.
  task automatic send_and_check(input logic [7:0] b);
    logic [10:0] frame;
    logic [15:0] rd;
`ifdef UART_TX_PARITY_EN
    frame = {1'b1, ^b, b, 1'b0};
`else
    frame = {1'b0, 1'b1, b, 1'b0};
`endif
    bus_write(DADDR, {8'h00, b});
    bus_read(DADDR, rd);
    check("occ_after_push", rd, 16'd1);
    check("txd_edge_n", {15'd0, txd}, 16'd1);
    step();
    bus_read(DADDR, rd);
    check("occ_after_pop", rd, 16'd0);
    check("txd_edge_n1", {15'd0, txd}, 16'd1);
    for (int i = 0; i < FRAME; i++) begin
      step();
      check("frame_txd", {15'd0, txd}, {15'd0, frame[i / BAUD]});
    end
    step();
    bus_read(CADDR, rd);
    check("ctrl_idle_after_frame", rd, 16'h0021 | PAR);
  endtask

  initial begin
    logic [15:0] rd;
    int e2;
    int waited;
    int lows;

    init = 1'b1;
    lock = 1'b1;
    re   = 1'b0;
    we   = 1'b0;
    abus = 16'h0000;
    wbus = 16'h0000;
    repeat (2) step();
    init = 1'b0;
    step();

    // Reset state and bus decode.
    bus_read(CADDR, rd);
    check("ctrl_after_reset", rd, 16'h0021 | PAR);
    bus_read(DADDR, rd);
    check("occ_after_reset", rd, 16'd0);
    check("txd_after_reset", {15'd0, txd}, 16'd1);
    check("intr_after_reset", {15'd0, intr}, 16'd0);
    abus = 16'h1234;
    re   = 1'b1;
    #1;
    checks++;
    assert (rbus === 16'hzzzz) else begin
      failures++;
      $error("FAIL rbus_z_nomatch: observed=%h expected=zzzz", rbus);
    end
    re   = 1'b0;
    abus = DADDR;
    #1;
    checks++;
    assert (rbus === 16'hzzzz) else begin
      failures++;
      $error("FAIL rbus_z_no_re: observed=%h expected=zzzz", rbus);
    end

    // Writes are ignored while the PLL is unlocked.
    lock = 1'b0;
    bus_write(DADDR, 16'h0055);
    bus_write(CADDR, 16'h0010);
    bus_read(DADDR, rd);
    check("occ_unlocked_write", rd, 16'd0);
    check("intr_unlocked_write", {15'd0, intr}, 16'd0);
    lock = 1'b1;
    step();
    check("txd_unlocked_write", {15'd0, txd}, 16'd1);

    // Single frames.
    send_and_check(8'hA5);
    send_and_check(8'h07);

    // Interrupt enable, then fill past full.
    bus_write(CADDR, 16'h0010);
    check("intr_enabled", {15'd0, intr}, 16'd1);
    bus_read(CADDR, rd);
    check("ctrl_ie_set", rd, 16'h0031 | PAR);
    bus_write(DADDR, 16'h0011);
    bus_write(DADDR, 16'h0022);
    e2 = cyc;
    bus_write(DADDR, 16'h0033);
    bus_write(DADDR, 16'h0044);
    bus_write(DADDR, 16'h0055);
    check("intr_fifo_full", {15'd0, intr}, 16'd0);
    bus_write(DADDR, 16'h0066);
    bus_read(DADDR, rd);
    check("occ_full", rd, 16'd4);
    bus_read(CADDR, rd);
    check("ctrl_overrun", rd, 16'h0014 | PAR);
    bus_write(CADDR, 16'h0014);
    bus_read(CADDR, rd);
    check("ctrl_ovr_write1_keeps", rd, 16'h0014 | PAR);
    bus_write(CADDR, 16'h0010);
    bus_read(CADDR, rd);
    check("ctrl_ovr_cleared", rd, 16'h0010 | PAR);
    bus_write(CADDR, 16'h0014);
    bus_read(CADDR, rd);
    check("ctrl_ovr_write1_nosets", rd, 16'h0010 | PAR);
    check("intr_still_full", {15'd0, intr}, 16'd0);
    waited = 0;
    while (intr !== 1'b1 && waited < 200) begin
      step();
      waited++;
    end
    check("intr_rise_cycle", 16'(cyc - e2), 16'(FRAME + 1));
    bus_read(DADDR, rd);
    check("occ_after_second_pop", rd, 16'd3);

    // Flush, then reset in the middle of a frame.
    init = 1'b1;
    step();
    init = 1'b0;
    step();
    bus_write(CADDR, 16'h0010);
    bus_write(DADDR, 16'h003C);
    bus_write(DADDR, 16'h00FF);
    repeat (6) step();
    check("txd_3c_bit0", {15'd0, txd}, 16'd0);
    #2;
    init = 1'b1;
    #1;
    check("txd_async_reset", {15'd0, txd}, 16'd1);
    bus_read(DADDR, rd);
    check("occ_in_reset", rd, 16'd0);
    bus_read(CADDR, rd);
    check("ctrl_in_reset", rd, 16'h0021 | PAR);
    check("intr_in_reset", {15'd0, intr}, 16'd0);
    step();
    init = 1'b0;
    lows = 0;
    repeat (60) begin
      step();
      if (txd !== 1'b1) lows++;
    end
    check("txd_low_after_reset", 16'(lows), 16'd0);
    bus_read(CADDR, rd);
    check("ctrl_after_mid_reset", rd, 16'h0021 | PAR);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
